// File: rtl/branch_predictor_if.sv
// IF/EX-facing bundle of the branch predictor: lookup, resolve-update, clear and perf counters.
// The slave modport is the predictor; the master is the datapath driving it.
interface branch_predictor_if #(
  parameter int unsigned ADDR_W = 32
);
  // IF-stage lookup
  logic [ADDR_W-1:0] lookup_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_next_pc;

  // EX-stage resolved outcome
  logic              upd_en;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_pred_taken;
  logic [ADDR_W-1:0] upd_pred_pc;
  logic              clear;
  logic              mispredict;

  // Performance counters
  logic [31:0]       branch_cnt;
  logic [31:0]       mispredict_cnt;

  modport master (
    output lookup_pc,
    input  pred_hit,
    input  pred_taken,
    input  pred_next_pc,
    output upd_en,
    output upd_pc,
    output upd_taken,
    output upd_target,
    output upd_pred_taken,
    output upd_pred_pc,
    output clear,
    input  mispredict,
    input  branch_cnt,
    input  mispredict_cnt
  );

  modport slave (
    input  lookup_pc,
    output pred_hit,
    output pred_taken,
    output pred_next_pc,
    input  upd_en,
    input  upd_pc,
    input  upd_taken,
    input  upd_target,
    input  upd_pred_taken,
    input  upd_pred_pc,
    input  clear,
    output mispredict,
    output branch_cnt,
    output mispredict_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is combinational for IF; EX writes resolved outcomes back on the clock edge.
module branch_predictor #(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned ADDR_W   = 32
) (
  input logic               CLK,
  input logic               nRST,
  branch_predictor_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  // Weakly not-taken on reset/clear, weakly taken on allocation.
  localparam logic [CTR_BITS-1:0] CtrInit  = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CtrAlloc = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CtrMax   = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CtrMin   = '0;
  localparam logic [CTR_BITS-1:0] CtrOne   = CTR_BITS'(1);

  // Table storage
  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [TAG_W-1:0]    tag_d    [ENTRIES];
  logic [ADDR_W-1:0]   target_q [ENTRIES];
  logic [ADDR_W-1:0]   target_d [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [CTR_BITS-1:0] ctr_d    [ENTRIES];

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

  // Address decode
  logic [IDX_W-1:0] lookup_idx;
  logic [TAG_W-1:0] lookup_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             mispredict;

  assign lookup_idx = bus.lookup_pc[IDX_W+1:2];
  assign lookup_tag = bus.lookup_pc[ADDR_W-1:IDX_W+2];
  assign upd_idx    = bus.upd_pc[IDX_W+1:2];
  assign upd_tag    = bus.upd_pc[ADDR_W-1:IDX_W+2];

  // Word-aligned PCs: the byte offset never reaches the table.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};

  // ---------------------------------------------------------------------------
  // Lookup: reads only registered state, so a same-cycle update is not bypassed.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.pred_hit     = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
    bus.pred_taken   = bus.pred_hit && ctr_q[lookup_idx][CTR_BITS-1];
    bus.pred_next_pc = bus.pred_taken ? target_q[lookup_idx]
                                      : bus.lookup_pc + ADDR_W'(4);
  end

  // ---------------------------------------------------------------------------
  // Mispredict: wrong direction, or taken to a different target than predicted.
  // ---------------------------------------------------------------------------
  always_comb begin
    mispredict = bus.upd_en &&
                 ((bus.upd_pred_taken != bus.upd_taken) ||
                  (bus.upd_taken && (bus.upd_pred_pc != bus.upd_target)));
  end

  assign bus.mispredict = mispredict;

  // ---------------------------------------------------------------------------
  // Table next state
  // ---------------------------------------------------------------------------
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;

    if (bus.clear) begin
      // Clear wins over any update arriving in the same cycle.
      for (int i = 0; i < ENTRIES; i++) begin
        valid_d[i] = 1'b0;
        ctr_d[i]   = CtrInit;
      end
    end else if (bus.upd_en) begin
      if (upd_hit) begin
        if (bus.upd_taken) begin
          target_d[upd_idx] = bus.upd_target;
          if (ctr_q[upd_idx] != CtrMax) begin
            ctr_d[upd_idx] = ctr_q[upd_idx] + CtrOne;
          end
        end else if (ctr_q[upd_idx] != CtrMin) begin
          ctr_d[upd_idx] = ctr_q[upd_idx] - CtrOne;
        end
      end else if (bus.upd_taken) begin
        // Taken miss allocates, evicting any aliasing entry at this index.
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = bus.upd_target;
        ctr_d[upd_idx]    = CtrAlloc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters: saturate at all-ones, unaffected by clear.
  // ---------------------------------------------------------------------------
  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (bus.upd_en && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (mispredict && (mispredict_cnt_q != '1)) begin
      mispredict_cnt_d = mispredict_cnt_q + 32'd1;
    end
  end

  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispredict_cnt = mispredict_cnt_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CtrInit;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        ctr_q[i]    <= ctr_d[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: stimulus pushes hand-computed expectations,
// a negedge monitor pops one per cycle and compares against the DUT outputs.
module tb_branch_predictor;

  logic CLK;
  logic nRST;

  branch_predictor_if #(.ADDR_W(32)) bus ();

  branch_predictor #(
    .ENTRIES (16),
    .CTR_BITS(2),
    .ADDR_W  (32)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        hit;
    logic        taken;
    logic [31:0] npc;
    logic        misp;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t scb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic drive(input logic [31:0] lpc, input logic en, input logic [31:0] pc,
                       input logic tk, input logic [31:0] tgt, input logic ptk,
                       input logic [31:0] ppc, input logic clr);
    bus.lookup_pc      = lpc;
    bus.upd_en         = en;
    bus.upd_pc         = pc;
    bus.upd_taken      = tk;
    bus.upd_target     = tgt;
    bus.upd_pred_taken = ptk;
    bus.upd_pred_pc    = ppc;
    bus.clear          = clr;
  endtask

  task automatic exp_push(input string name, input logic hit, input logic taken,
                          input logic [31:0] npc, input logic misp,
                          input logic [31:0] bc, input logic [31:0] mc);
    exp_t e;
    e.name = name; e.hit = hit; e.taken = taken; e.npc = npc;
    e.misp = misp; e.bc = bc; e.mc = mc;
    scb.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: combinational outputs are stable mid-cycle, compare at the negedge.
  always @(negedge CLK) begin
    if (scb.size() != 0) begin
      exp_t e;
      e = scb.pop_front();
      checks++;
      if ({bus.pred_hit, bus.pred_taken, bus.pred_next_pc, bus.mispredict,
           bus.branch_cnt, bus.mispredict_cnt} !==
          {e.hit, e.taken, e.npc, e.misp, e.bc, e.mc}) begin
        errors++;
        $display("FAIL %s: got hit=%0b taken=%0b npc=%h misp=%0b bc=%0d mc=%0d, want hit=%0b taken=%0b npc=%h misp=%0b bc=%0d mc=%0d",
                 e.name, bus.pred_hit, bus.pred_taken, bus.pred_next_pc, bus.mispredict,
                 bus.branch_cnt, bus.mispredict_cnt,
                 e.hit, e.taken, e.npc, e.misp, e.bc, e.mc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want run to finish");
    $fatal(1, "timeout");
  end

  initial begin
    nRST = 1'b0;
    drive(32'h40, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    tick();
    tick();

    // Reset state
    drive(32'h40, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    exp_push("reset", 0, 0, 32'h44, 0, 0, 0);
    tick();
    nRST = 1'b1;

    // First taken resolve of 0x40: miss -> allocate, mispredicted
    drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b0);
    exp_push("alloc_misp", 0, 0, 32'h44, 1, 0, 0);
    tick();
    drive(32'h40, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    exp_push("alloc_hit", 1, 1, 32'h100, 0, 1, 1);
    tick();

    // Three not-taken: counter 2->1->0->0
    drive(32'h40, 1'b1, 32'h40, 1'b0, '0, 1'b1, 32'h100, 1'b0);
    exp_push("nt1", 1, 1, 32'h100, 1, 1, 1);
    tick();
    drive(32'h40, 1'b1, 32'h40, 1'b0, '0, 1'b0, 32'h44, 1'b0);
    exp_push("nt2", 1, 0, 32'h44, 0, 2, 2);
    tick();
    drive(32'h40, 1'b1, 32'h40, 1'b0, '0, 1'b0, 32'h44, 1'b0);
    exp_push("nt3_sat0", 1, 0, 32'h44, 0, 3, 2);
    tick();

    // Two taken: counter 0->1->2; second one also checks no same-cycle bypass
    drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b0);
    exp_push("tk1", 1, 0, 32'h44, 1, 4, 2);
    tick();
    drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b0);
    exp_push("tk2_old_pred", 1, 0, 32'h44, 1, 5, 3);
    tick();

    // New prediction visible; update a different index with a wrong target
    drive(32'h40, 1'b1, 32'h44, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0);
    exp_push("tk2_new_pred_tgt_misp", 1, 1, 32'h100, 1, 6, 4);
    tick();
    drive(32'h44, 1'b1, 32'h44, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0);
    exp_push("idx1_correct", 1, 1, 32'h200, 0, 7, 5);
    tick();

    // Aliasing: 0x80 shares index 0 with 0x40
    drive(32'h80, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    exp_push("alias_miss", 0, 0, 32'h84, 0, 8, 5);
    tick();
    drive(32'h80, 1'b1, 32'h80, 1'b1, 32'h180, 1'b0, 32'h84, 1'b0);
    exp_push("alias_alloc", 0, 0, 32'h84, 1, 8, 5);
    tick();
    drive(32'h80, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    exp_push("alias_hit", 1, 1, 32'h180, 0, 9, 6);
    tick();
    drive(32'h40, 1'b1, 32'h40, 1'b0, '0, 1'b0, 32'h44, 1'b0);
    exp_push("evicted_nt_miss", 0, 0, 32'h44, 0, 9, 6);
    tick();
    drive(32'h80, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    exp_push("alias_kept", 1, 1, 32'h180, 0, 10, 6);
    tick();

    // Clear with a same-cycle taken update to 0xC0
    drive(32'h44, 1'b1, 32'hC0, 1'b1, 32'h300, 1'b0, 32'hC4, 1'b1);
    exp_push("clear_cycle", 1, 1, 32'h200, 1, 10, 6);
    tick();
    drive(32'hC0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    exp_push("clear_c0", 0, 0, 32'hC4, 0, 11, 7);
    tick();
    drive(32'h80, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    exp_push("clear_80", 0, 0, 32'h84, 0, 11, 7);
    tick();
    drive(32'h44, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    exp_push("clear_44", 0, 0, 32'h48, 0, 11, 7);
    tick();

    // Reallocation after clear
    drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b0);
    exp_push("realloc", 0, 0, 32'h44, 1, 11, 7);
    tick();
    drive(32'h40, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    exp_push("realloc_hit", 1, 1, 32'h100, 0, 12, 8);
    tick();

    // pred_next_pc wraps
    drive(32'hFFFF_FFFC, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    exp_push("wrap", 0, 0, 32'h0, 0, 12, 8);
    tick();

    // Asynchronous reset mid-cycle, checked before the next clock edge
    drive(32'h40, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    #1;
    nRST = 1'b0;
    exp_push("async_reset", 0, 0, 32'h44, 0, 0, 0);
    tick();
    nRST = 1'b1;
    drive(32'h40, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    exp_push("post_reset", 0, 0, 32'h44, 0, 0, 0);
    tick();

    @(negedge CLK);
    #1;
    checks++;
    if (scb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", scb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
